// File: rtl/rounding_pkg.sv
// Shared types for the rounding shift datapath: rounding-mode encoding and
// the width of the optional saturation event counter.
package rounding_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2,
    RND_CEIL      = 2'd3
  } round_mode_e;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/rounding_core.sv
// Combinational round-increment decision from the guard (half) bit, the sticky
// bit and the quotient LSB. Kept sign-agnostic so signed variants can reuse it.
module rounding_core
  import rounding_pkg::*;
(
  input  logic        q_lsb,
  input  logic        half,
  input  logic        sticky,
  input  round_mode_e mode,
  output logic        inc
);

  always_comb begin
    inc = 1'b0;
    unique case (mode)
      RND_TRUNC:     inc = 1'b0;
      RND_HALF_UP:   inc = half;
      RND_HALF_EVEN: inc = half && (sticky || q_lsb);
      RND_CEIL:      inc = half || sticky;
      default:       inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/rounding_shift_pipe.sv
// Two-stage valid/ready pipeline dividing by 2^shift with selectable rounding
// and saturation. Define ROUNDING_SAT_COUNT_EN to add the sat_count port.
module rounding_shift_pipe
  import rounding_pkg::*;
#(
  parameter int OUT_WIDTH = 32,
  parameter int MAX_SHIFT = 8,
  parameter int SHIFT_W   = $clog2(MAX_SHIFT + 1),
  parameter int IN_WIDTH  = OUT_WIDTH + MAX_SHIFT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [SHIFT_W-1:0]   in_shift,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
`ifdef ROUNDING_SAT_COUNT_EN
  ,
  output logic [SAT_CNT_W-1:0] sat_count
`endif
);

  localparam logic [SHIFT_W-1:0] MAX_SH = SHIFT_W'(MAX_SHIFT);

  logic [SHIFT_W-1:0]   sh;
  logic [IN_WIDTH-1:0]  q;
  logic [MAX_SHIFT-1:0] half_bits;
  logic [MAX_SHIFT-1:0] sticky_bits;

  logic                 s1_valid;
  logic [IN_WIDTH-1:0]  s1_q;
  logic                 s1_half;
  logic                 s1_sticky;
  round_mode_e          s1_mode;
  logic                 s1_adv;

  logic                 s2_valid;
  logic                 inc;
  logic [IN_WIDTH:0]    r;
  logic                 sat;

  assign sh = (in_shift > MAX_SH) ? MAX_SH : in_shift;
  assign q  = in_data >> sh;

  // Bit gi is the half bit when sh == gi+1, and a sticky bit when sh > gi+1.
  generate
    for (genvar gi = 0; gi < MAX_SHIFT; gi++) begin : g_round_bits
      assign half_bits[gi]   = (sh == SHIFT_W'(gi + 1)) && in_data[gi];
      assign sticky_bits[gi] = (sh >  SHIFT_W'(gi + 1)) && in_data[gi];
    end
  endgenerate

  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      s1_half   <= 1'b0;
      s1_sticky <= 1'b0;
      s1_mode   <= RND_TRUNC;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q      <= q;
        s1_half   <= |half_bits;
        s1_sticky <= |sticky_bits;
        s1_mode   <= round_mode_e'(in_mode);
      end
    end
  end

  rounding_core u_core (
    .q_lsb  (s1_q[0]),
    .half   (s1_half),
    .sticky (s1_sticky),
    .mode   (s1_mode),
    .inc    (inc)
  );

  // One extra bit so an increment out of an all-ones quotient is still seen.
  assign r   = {1'b0, s1_q} + {{IN_WIDTH{1'b0}}, inc};
  assign sat = |r[IN_WIDTH:OUT_WIDTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat ? {OUT_WIDTH{1'b1}} : r[OUT_WIDTH-1:0];
        out_sat  <= sat;
      end
    end
  end

  assign out_valid = s2_valid;

`ifdef ROUNDING_SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_count != {SAT_CNT_W{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rounding_shift_pipe.sv
// Directed bench for rounding_shift_pipe: vector table of single beats, a
// backpressured stream, mid-flight reset and (optionally) the saturation counter.
module tb_rounding_shift_pipe;

  localparam int OUT_W = 32;
  localparam int IN_W  = 40;
  localparam int SH_W  = 4;
  localparam int NVEC  = 15;
  localparam int NSTREAM = 10;

  typedef struct {
    logic [IN_W-1:0]  data;
    logic [SH_W-1:0]  shift;
    logic [1:0]       mode;
    logic [OUT_W-1:0] exp_data;
    logic             exp_sat;
  } vec_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [SH_W-1:0]  in_shift;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
`ifdef ROUNDING_SAT_COUNT_EN
  logic [15:0]      sat_count;
`endif

  int errors = 0;
  int checks = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  rounding_shift_pipe dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef ROUNDING_SAT_COUNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One isolated beat with out_ready high: checks latency 2 and the result.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = v.data;
    in_shift  = v.shift;
    in_mode   = v.mode;
    #1 check("idle_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("latency_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check("latency_valid", 64'(out_valid), 64'd1);
    check("vec_data", 64'(out_data), 64'(v.exp_data));
    check("vec_sat", 64'(out_sat), 64'(v.exp_sat));
    $display("vec %0d: data=0x%0h shift=%0d mode=%0d -> out=0x%0h sat=%0d (want 0x%0h/%0d)",
             idx, v.data, v.shift, v.mode, out_data, out_sat, v.exp_data, v.exp_sat);
  endtask

  function automatic logic [IN_W-1:0] stream_in(input int i);
    return IN_W'(i * 1237 + 6);
  endfunction

  initial begin
    int sent, rcvd, cyc;
    logic held_v;
    logic [OUT_W-1:0] held_d;
    logic exp_rdy;
    logic [IN_W-1:0] d;

    //           data              sh  mode  expected       sat
    vecs[0]  = '{40'd20,           4'd3, 2'd0, 32'd2,        1'b0};
    vecs[1]  = '{40'd20,           4'd3, 2'd1, 32'd3,        1'b0};
    vecs[2]  = '{40'd20,           4'd3, 2'd2, 32'd2,        1'b0};
    vecs[3]  = '{40'd20,           4'd3, 2'd3, 32'd3,        1'b0};
    vecs[4]  = '{40'd28,           4'd3, 2'd2, 32'd4,        1'b0};
    vecs[5]  = '{40'd17,           4'd3, 2'd3, 32'd3,        1'b0};
    vecs[6]  = '{40'd17,           4'd3, 2'd1, 32'd2,        1'b0};
    vecs[7]  = '{40'hFF_FFFF_FFFF, 4'd8, 2'd1, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{40'hFF_FFFF_FFFF, 4'd8, 2'd0, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{40'h01_0000_0000, 4'd0, 2'd0, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{40'h300,          4'd15, 2'd0, 32'd3,       1'b0};
    vecs[11] = '{40'h2FF,          4'd8, 2'd2, 32'd3,        1'b0};
    vecs[12] = '{40'd5,            4'd1, 2'd2, 32'd2,        1'b0};
    vecs[13] = '{40'd7,            4'd1, 2'd2, 32'd4,        1'b0};
    vecs[14] = '{40'd12345,        4'd0, 2'd3, 32'd12345,    1'b0};

    resetn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_shift = '0;
    in_mode = 2'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_sat", 64'(out_sat), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Continuous stream, out_ready pattern 1,0,0,1 repeating, HALF_UP shift 2.
    sent = 0;
    rcvd = 0;
    held_v = 1'b0;
    held_d = '0;
    for (cyc = 0; cyc < 200 && rcvd < NSTREAM; cyc++) begin
      @(negedge clk);
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < NSTREAM);
      in_data   = stream_in(sent);
      in_shift  = 4'd2;
      in_mode   = 2'd1;
      #1;
      exp_rdy = !(((sent - rcvd) == 2) && !out_ready);
      check("stream_in_ready", 64'(in_ready), 64'(exp_rdy));
      if (held_v) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(held_d));
      end
      if (out_valid && out_ready) begin
        d = stream_in(rcvd);
        check("stream_data", 64'(out_data), 64'((d + 40'd2) >> 2));
        $display("stream beat %0d: out=0x%0h at cycle %0d", rcvd, out_data, cyc);
        rcvd++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (in_valid && in_ready) sent++;
    end
    check("stream_all_received", 64'(rcvd), 64'(NSTREAM));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset with two beats held in the pipe.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_shift  = 4'd0;
    in_mode   = 2'd0;
    in_data   = 40'd100;
    @(negedge clk);
    in_data = 40'd200;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset_full_valid", 64'(out_valid), 64'd1);
    check("pre_reset_full_ready", 64'(in_ready), 64'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_reset_valid", 64'(out_valid), 64'd0);
    check("post_reset_data", 64'(out_data), 64'd0);
    check("post_reset_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("flushed_no_output", 64'(out_valid), 64'd0);
    end
    $display("reset flush: in-flight beats discarded");

`ifdef ROUNDING_SAT_COUNT_EN
    check("sat_count_after_reset", 64'(sat_count), 64'd0);
    for (int i = 0; i < 3; i++) run_vec(100 + i, vecs[7]);
    @(negedge clk);
    #1 check("sat_count_three", 64'(sat_count), 64'd3);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1 check("sat_count_cleared", 64'(sat_count), 64'd0);
    $display("sat_count: counted and cleared");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
